// File: rtl/trb_st2bus_pack.sv
// Packs an 8-bit stream LSB-first into BUS_OUT-bit words behind a small word FIFO; one-cycle push-to-head latency.
// Backpressure: st_ready drops only when the word FIFO is full, so out_ready never reaches st_ready combinationally.

// Generic word FIFO: head visible the cycle after a push into an empty FIFO.
// Writer must respect count < DEPTH; rd_dat reads as zero while empty.
module trb_st2bus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_st,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign rd_vld = (count_q != '0);
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign count  = count_q;
  assign do_pop = rd_rdy && rd_vld;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_vld) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(wr_vld) - CW'(do_pop);
  end

  always_ff @(posedge clk_st) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// Byte-to-word packer with framing checks; completing byte lands at the FIFO head next cycle.
// Accepts bytes only while the word FIFO has room; stalls upstream otherwise.
module trb_st2bus_pack #(
  parameter int ST         = 8,
  parameter int BUS_OUT    = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_st,
  input  logic               rst,
  input  logic [ST-1:0]      st_data,
  input  logic               st_valid,
  input  logic               st_sop,
  input  logic               st_eop,
  output logic               st_ready,
  output logic [BUS_OUT-1:0] out_data,
  output logic [6:0]         out_nbytes,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        err_cnt
);
  localparam int BPW = BUS_OUT / ST;
  localparam int IW  = $clog2(BPW);
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  typedef enum logic {IDLE, PKT} state_t;

  typedef struct packed {
    logic               last;
    logic [6:0]         nbytes;
    logic [BUS_OUT-1:0] data;
  } word_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, base_idx;
  logic [BUS_OUT-1:0] pack_q, pack_d, word_v;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic               rst_q;
  logic               accept, push_vld;
  word_t              push_dat, head;
  logic [CW-1:0]      fifo_count;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign st_ready   = !rst_q && (fifo_count < CW'(FIFO_DEPTH));
  assign accept     = st_valid && st_ready;
  assign out_data   = head.data;
  assign out_nbytes = head.nbytes;
  assign out_last   = head.last;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pack_d    = pack_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    push_vld  = 1'b0;
    push_dat  = '0;
    word_v    = '0;
    base_idx  = '0;
    if (accept) begin
      if (state_q == IDLE && !st_sop) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end else begin
        // A sop always restarts at byte 0; inside a packet it also abandons the partial word.
        if (st_sop) begin
          if (state_q == PKT) err_cnt_d = sat_inc(err_cnt_q);
        end else begin
          base_idx = idx_q;
          word_v   = pack_q;
        end
        word_v[int'(base_idx)*ST +: ST] = st_data;
        if (st_eop || base_idx == IW'(BPW-1)) begin
          push_vld        = 1'b1;
          push_dat.data   = word_v;
          push_dat.nbytes = 7'(base_idx) + 7'd1;
          push_dat.last   = st_eop;
          pack_d          = '0;
          idx_d           = '0;
          state_d         = st_eop ? IDLE : PKT;
          if (st_eop) pkt_cnt_d = sat_inc(pkt_cnt_q);
        end else begin
          pack_d  = word_v;
          idx_d   = base_idx + 1'b1;
          state_d = PKT;
        end
      end
    end
  end

  always_ff @(posedge clk_st) begin
    rst_q <= rst;
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pack_q    <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pack_q    <= pack_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  trb_st2bus_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_st (clk_st),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (head),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_trb_st2bus_pack.sv
// Directed bench for trb_st2bus_pack: packet table plus hand-written backpressure, framing and reset sequences.
module tb_trb_st2bus_pack;
  localparam int BUS = 512;

  logic            clk_st = 1'b0;
  logic            rst;
  logic [7:0]      st_data;
  logic            st_valid, st_sop, st_eop, st_ready;
  logic [BUS-1:0]  out_data;
  logic [6:0]      out_nbytes;
  logic            out_last, out_valid, out_ready;
  logic [15:0]     pkt_cnt, err_cnt;

  always #5 clk_st = ~clk_st;

  trb_st2bus_pack #(.ST(8), .BUS_OUT(BUS), .FIFO_DEPTH(4)) dut (
    .clk_st     (clk_st),
    .rst        (rst),
    .st_data    (st_data),
    .st_valid   (st_valid),
    .st_sop     (st_sop),
    .st_eop     (st_eop),
    .st_ready   (st_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic [BUS-1:0] data;
    logic [6:0]     nbytes;
    logic           last;
  } word_t;

  typedef struct {
    int         len;
    logic [7:0] base;
    int         exp_words;
    int         exp_last_n;
  } vec_t;

  word_t got[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    exp_pkt  = 0;
  int    exp_err  = 0;

  // Words are recorded on the negedge preceding the edge that pops them.
  always @(negedge clk_st)
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      got.push_back('{out_data, out_nbytes, out_last});

  task automatic chk(input string nm, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_st);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int t = 0;
    st_data  = d;
    st_sop   = s;
    st_eop   = e;
    st_valid = 1'b1;
    @(negedge clk_st);
    while (st_ready !== 1'b1 && t < 100) begin
      @(negedge clk_st);
      t++;
    end
    if (t >= 100) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_byte timeout: st_ready=%b required 1", st_ready);
    end
    @(posedge clk_st);
    #1;
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) send_byte(base + 8'(i), i == 0, i == len - 1);
  endtask

  function automatic logic [BUS-1:0] exp_word(input logic [7:0] base, input int start, input int n);
    logic [BUS-1:0] e = '0;
    for (int k = 0; k < n; k++) e[k*8 +: 8] = base + 8'(start + k);
    return e;
  endfunction

  task automatic check_word(input string nm, input logic [7:0] base, input int start,
                            input int n, input bit last);
    word_t w;
    chk({nm, " present"}, BUS'(got.size() > 0), BUS'(1));
    if (got.size() > 0) begin
      w = got.pop_front();
      chk({nm, " data"},   w.data,          exp_word(base, start, n));
      chk({nm, " nbytes"}, BUS'(w.nbytes),  BUS'(n));
      chk({nm, " last"},   BUS'(w.last),    BUS'(last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{1,   8'h10, 1, 1};
    tbl[1] = '{63,  8'h20, 1, 63};
    tbl[2] = '{64,  8'h30, 1, 64};
    tbl[3] = '{65,  8'h40, 2, 1};
    tbl[4] = '{130, 8'h80, 3, 2};

    rst = 1'b1; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk_st);
    @(negedge clk_st);
    chk("reset st_ready",   BUS'(st_ready),   BUS'(0));
    chk("reset out_valid",  BUS'(out_valid),  BUS'(0));
    chk("reset out_data",   out_data,         '0);
    chk("reset out_nbytes", BUS'(out_nbytes), BUS'(0));
    chk("reset out_last",   BUS'(out_last),   BUS'(0));
    chk("reset pkt_cnt",    BUS'(pkt_cnt),    BUS'(0));
    chk("reset err_cnt",    BUS'(err_cnt),    BUS'(0));
    @(posedge clk_st); #1; rst = 1'b0;
    idle(2);
    @(negedge clk_st);
    chk("post-reset st_ready", BUS'(st_ready), BUS'(1));
    @(posedge clk_st); #1;

    // 128-byte block -> two full words
    got.delete();
    send_pkt(128, 8'h00);
    idle(6);
    exp_pkt++;
    chk("blk128 nwords", BUS'(got.size()), BUS'(2));
    check_word("blk128 w0", 8'h00, 0, 64, 1'b0);
    check_word("blk128 w1", 8'h00, 64, 64, 1'b1);
    chk("blk128 pkt_cnt", BUS'(pkt_cnt), BUS'(exp_pkt));
    chk("blk128 err_cnt", BUS'(err_cnt), BUS'(exp_err));

    // single-byte packet
    got.delete();
    send_byte(8'hA5, 1'b1, 1'b1);
    idle(4);
    exp_pkt++;
    check_word("single", 8'hA5, 0, 1, 1'b1);
    chk("single pkt_cnt", BUS'(pkt_cnt), BUS'(exp_pkt));

    for (int v = 0; v < 5; v++) begin
      got.delete();
      send_pkt(tbl[v].len, tbl[v].base);
      idle(6);
      exp_pkt++;
      chk($sformatf("vec%0d nwords", v), BUS'(got.size()), BUS'(tbl[v].exp_words));
      for (int w = 0; w < tbl[v].exp_words; w++) begin
        bit lst;
        lst = (w == tbl[v].exp_words - 1);
        check_word($sformatf("vec%0d w%0d", v, w), tbl[v].base, w * 64,
                   lst ? tbl[v].exp_last_n : 64, lst);
      end
      chk($sformatf("vec%0d pkt_cnt", v), BUS'(pkt_cnt), BUS'(exp_pkt));
    end

    // bytes without sop while idle are dropped
    got.delete();
    for (int i = 0; i < 3; i++) send_byte(8'h11 + 8'(i), 1'b0, 1'b0);
    idle(4);
    exp_err += 3;
    chk("nosop nwords",   BUS'(got.size()), BUS'(0));
    chk("nosop err_cnt",  BUS'(err_cnt),    BUS'(exp_err));
    @(negedge clk_st);
    chk("nosop st_ready", BUS'(st_ready),   BUS'(1));
    @(posedge clk_st); #1;

    // sop in mid-packet abandons packet A
    got.delete();
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i), i == 0, 1'b0);
    send_pkt(70, 8'h00);
    idle(6);
    exp_err++;
    exp_pkt++;
    chk("resop nwords", BUS'(got.size()), BUS'(2));
    check_word("resop w0", 8'h00, 0, 64, 1'b0);
    check_word("resop w1", 8'h00, 64, 6, 1'b1);
    chk("resop err_cnt", BUS'(err_cnt), BUS'(exp_err));
    chk("resop pkt_cnt", BUS'(pkt_cnt), BUS'(exp_pkt));

    // host backpressure: fill FIFO, stall, then drain
    got.delete();
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(64, 8'(p * 64));
    @(negedge clk_st);
    chk("full st_ready",  BUS'(st_ready),  BUS'(0));
    chk("full out_valid", BUS'(out_valid), BUS'(1));
    @(posedge clk_st); #1;
    fork
      send_pkt(64, 8'h00);
      begin
        repeat (20) @(negedge clk_st);
        chk("stall st_ready",   BUS'(st_ready),   BUS'(0));
        chk("stall head data",  out_data,         exp_word(8'h00, 0, 64));
        chk("stall head nbytes", BUS'(out_nbytes), BUS'(64));
        chk("stall nwords",     BUS'(got.size()), BUS'(0));
        @(posedge clk_st); #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    exp_pkt += 5;
    chk("drain nwords", BUS'(got.size()), BUS'(5));
    for (int p = 0; p < 5; p++)
      check_word($sformatf("drain w%0d", p), 8'(p * 64), 0, 64, 1'b1);
    chk("drain pkt_cnt", BUS'(pkt_cnt), BUS'(exp_pkt));

    // reset mid-packet
    got.delete();
    for (int i = 0; i < 40; i++) send_byte(8'h70 + 8'(i), i == 0, 1'b0);
    rst = 1'b1;
    @(posedge clk_st); #1;
    rst = 1'b0;
    @(negedge clk_st);
    chk("midrst out_valid", BUS'(out_valid), BUS'(0));
    chk("midrst pkt_cnt",   BUS'(pkt_cnt),   BUS'(0));
    chk("midrst err_cnt",   BUS'(err_cnt),   BUS'(0));
    @(posedge clk_st); #1;
    exp_pkt = 0;
    exp_err = 0;
    send_pkt(128, 8'h55);
    idle(6);
    exp_pkt++;
    chk("postrst nwords", BUS'(got.size()), BUS'(2));
    check_word("postrst w0", 8'h55, 0, 64, 1'b0);
    check_word("postrst w1", 8'h55, 64, 64, 1'b1);
    chk("postrst pkt_cnt", BUS'(pkt_cnt), BUS'(exp_pkt));
    chk("postrst err_cnt", BUS'(err_cnt), BUS'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
